pcie_egress_arb: RTL

Egress arbiter downstream of the PCIe transaction block. Consumes the two output FIFOs (D0, D1) through their `Dx_can_pop`/`pop_Dx` handshake and round-robin merges them into one registered stream with valid/ready flow control. Tags each word with its source and keeps per-port transfer counters for the test bench. Sits between the transaction block and the link-side serializer.

---
 rtl/pcie_egress_pkg.sv | 17 +
 rtl/pcie_egress_buf.sv | 40 ++++
 rtl/pcie_egress_arb.sv | 106 ++++++++++
 3 files changed

// File: rtl/pcie_egress_pkg.sv
// Shared definitions for the PCIe egress arbiter: source tags, buffer depth
// and the {src, data} buffer entry layout.
package pcie_egress_pkg;

  typedef enum logic {
    SRC_D0 = 1'b0,
    SRC_D1 = 1'b1
  } src_e;

  localparam int BUF_DEPTH = 2;

  // A buffer entry is the data word with its source tag prepended.
  function automatic int entry_width(input int bitnumber);
    return bitnumber + 1;
  endfunction

endpackage

// File: rtl/pcie_egress_buf.sv
// Two-entry synchronous FIFO holding {src, data} entries; exposes the head
// entry and the current fill count.
module pcie_egress_buf
  import pcie_egress_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage is cleared as well so the head reads 0 out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pcie_egress_arb.sv
// Round-robin egress arbiter merging the D0/D1 transaction FIFOs into one
// registered valid/ready stream, with source tagging and per-port counters.
module pcie_egress_arb
  import pcie_egress_pkg::*;
#(
  parameter int BITNUMBER = 6,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 D0_can_pop,
  input  logic                 D1_can_pop,
  input  logic [BITNUMBER-1:0] data_out0,
  input  logic [BITNUMBER-1:0] data_out1,
  output logic                 pop_D0,
  output logic                 pop_D1,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 src_out,
  output logic [CNT_WIDTH-1:0] cnt_D0,
  output logic [CNT_WIDTH-1:0] cnt_D1,
  output logic                 idle
);

  localparam int EW = entry_width(BITNUMBER);

  logic           in_flight;
  src_e           flight_src;
  src_e           last;
  src_e           grant;
  logic [1:0]     buf_count;
  logic [1:0]     occ;
  logic           drain;
  logic           permit;
  logic           pop_any;
  logic [EW-1:0]  push_data;
  logic [EW-1:0]  head;

  assign drain = valid_out & ready_in;
  // Occupancy reserves a buffer slot for the word still coming from a FIFO.
  assign occ     = buf_count + {1'b0, in_flight};
  assign permit  = (occ != 2'd2) | drain;
  assign pop_any = pop_D0 | pop_D1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    pop_D0 = 1'b0;
    pop_D1 = 1'b0;
    grant  = last;
    if (!reset && permit) begin
      unique case ({D1_can_pop, D0_can_pop})
        2'b01: begin grant = SRC_D0; pop_D0 = 1'b1; end
        2'b10: begin grant = SRC_D1; pop_D1 = 1'b1; end
        2'b11: begin
          grant  = (last == SRC_D1) ? SRC_D0 : SRC_D1;
          pop_D0 = (grant == SRC_D0);
          pop_D1 = (grant == SRC_D1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      in_flight  <= 1'b0;
      flight_src <= SRC_D0;
      last       <= SRC_D1;
    end else begin
      in_flight  <= pop_any;
      flight_src <= grant;
      if (pop_any) last <= grant;
    end
  end

  assign push_data = {flight_src, (flight_src == SRC_D1) ? data_out1 : data_out0};

  pcie_egress_buf #(.W(EW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight),
    .push_data (push_data),
    .pop       (drain),
    .head      (head),
    .count     (buf_count)
  );

  assign valid_out = (buf_count != 2'd0);
  assign src_out   = head[EW-1];
  assign data_out  = head[BITNUMBER-1:0];
  assign idle      = (occ == 2'd0);

  always_ff @(posedge clk) begin
    if (reset || init) begin
      cnt_D0 <= '0;
      cnt_D1 <= '0;
    end else if (drain) begin
      if (src_out) cnt_D1 <= cnt_D1 + 1'b1;
      else         cnt_D0 <= cnt_D0 + 1'b1;
    end
  end

endmodule
